mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data-memory bus, beside the data RAM. It consumes the core's store/load signals (addr, memWdata, memWMask, isStore) for its own address region. Bytes are queued in a small FIFO and serialised 8N1 on tx. The single-cycle core never stalls: status reads are combinational and writes to a full FIFO are dropped and flagged.

Parameters:
CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..256
BASE_NIB, 4'h4, addr[31:28] value that selects this block

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
addr  input  32  byte address from core ALU
memWdata  input  32  store data, already lane-aligned
memWMask  input  4  byte-lane write mask
isStore  input  1  current instruction is a store
sel  output  1  combinational: addr[31:28] == BASE_NIB
rdata  output  32  combinational read data; 0 when sel=0
tx  output  1  serial line, idle high, registered
txIdleIrq  output  1  registered: FIFO empty and FSM in IDLE

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Register map (word offset addr[3:2]; addr[27:4] ignored):
  - 0 TXDATA: write pushes memWdata[7:0] if memWMask[0]; reads as 0.
  - 1 STATUS: read {24'b0, count[3:0], ovf, empty, full, busy}. Writing with memWMask[0]=1 and memWdata[3]=1 clears ovf.
  - 2, 3: reserved; read 0, writes ignored.
- Write strobe: wr = isStore & sel, sampled at rising clk. Loads have no side effects.
- FIFO:
  - Push when wr to TXDATA with memWMask[0]=1.
  - Full means count == FIFO_DEPTH. Full is evaluated on pre-edge count, so a push while full is dropped and sets sticky ovf even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is (log2(FIFO_DEPTH)+1) bits. STATUS reports count[3:0], saturating at 15.
- FSM states and transitions:
  - IDLE: tx=1. If FIFO non-empty: pop into shift reg, go START.
  - START: tx=0 for CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each; bit index 0..7; after bit 7, go STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go IDLE.
- Baud counter: counts 0..CLK_DIV-1, reloads to 0 on every state entry; a bit ends when it reaches CLK_DIV-1.
- Frame = 10*CLK_DIV cycles.
- Latency: a push at edge N into an empty FIFO with FSM idle gives the pop at edge N+1; tx goes low after edge N+1.
- busy = (state != IDLE).
- reset (any cycle, including mid-frame): state IDLE, tx=1, FIFO flushed (count=0), ovf=0, txIdleIrq=0 on the reset cycle then 1. Output values: rdata/sel are combinational from inputs and state.

Optional Feature:
Macro UART_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and drives even parity (XOR of the 8 data bits) for CLK_DIV cycles; frame = 11*CLK_DIV. STATUS bit 8 reads 1 to indicate parity is present.
- Undefined: no PARITY state, 8N1, STATUS bit 8 reads 0.

Test Plan:
- Reset, CLK_DIV=4 -> tx=1, STATUS read=0x00000004 (empty), txIdleIrq=1 after reset released.
- Store 0xA5 to 0x40000000 -> tx low starting 1 cycle after the write edge. Line holds for 4 cycles each: 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); frame = 40 cycles; busy=1 throughout.
- Back-to-back: write 0x55 then 0x0F in consecutive cycles -> second start bit immediately follows the first stop bit with no idle cycle; STATUS count goes 1 then 0.
- Overflow: FIFO_DEPTH=8; 10 writes while frame 1 transmits -> the first byte is popped, so 9 writes are accepted (8 queued plus 1 in flight) and the 10th is dropped; full=1, ovf=1. Store 0x8 to 0x40000004 -> ovf=0.
- Reset asserted mid DATA bit 3 -> next cycle tx=1, state IDLE, count=0; no residual bits sent.
- Non-selected address (0x80000000 store, 0x4000000C read) -> no push, sel=0 / rdata=0 respectively. With UART_PARITY_EN, 0xA5 -> parity bit 0 precedes stop; frame = 44 cycles.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the core data bus.
// Latency: push at edge N into an idle, empty block pops at N+1; tx drops after N+1.
// Backpressure: none, the core never stalls; pushes into a full FIFO are dropped and set sticky ovf.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   addr, memWdata,
//   memWMask, isStore     core store/load bus; this block decodes addr[31:28] == BASE_NIB
//   sel, rdata            combinational select and read data (rdata = 0 when sel = 0)
//   tx                    registered serial line, idle high
//   txIdleIrq             registered: FIFO empty and transmitter idle
//
// Register map (word offset addr[3:2]):
//   0 TXDATA  write pushes memWdata[7:0] when memWMask[0]; reads 0
//   1 STATUS  {23'b0, parity_present, count[3:0], ovf, empty, full, busy};
//             write with memWMask[0] and memWdata[3] clears ovf
//   2,3       reserved
//
// Build option: define UART_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
    parameter int         CLK_DIV    = 868,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] BASE_NIB   = 4'h4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] memWdata,
    input  logic [3:0]  memWMask,
    input  logic        isStore,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        txIdleIrq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

`ifdef UART_PARITY_EN
    localparam logic PARITY_PRESENT = 1'b1;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
`else
    localparam logic PARITY_PRESENT = 1'b0;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } state_t;
`endif

    state_t          state_q, state_n;
    logic [BW-1:0]   baud_q, baud_n;
    logic [2:0]      idx_q, idx_n;
    logic [7:0]      data_q, data_n;
    logic            tx_n;
    logic            pop;
    logic            bit_end;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;
    logic            full, empty, busy;
    logic            wr, push_req, push, ovf_clr;
    logic [8:0]      count_ext;
    logic [3:0]      count4;
    logic [31:0]     status_word;
    logic            unused_bits;

    // Bus decode
    assign sel      = (addr[31:28] == BASE_NIB);
    assign wr       = isStore & sel;
    assign push_req = wr & (addr[3:2] == 2'd0) & memWMask[0];
    assign ovf_clr  = wr & (addr[3:2] == 2'd1) & memWMask[0] & memWdata[3];

    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = push_req & ~full;
    assign busy  = (state_q != S_IDLE);

    assign count_ext = 9'(count_q);
    assign count4    = (count_ext > 9'd15) ? 4'hF : count_ext[3:0];
    assign status_word = {23'b0, PARITY_PRESENT, count4, ovf_q, empty, full, busy};

    always_comb begin
        rdata = '0;
        if (sel && addr[3:2] == 2'd1)
            rdata = status_word;
    end

    assign unused_bits = ^{addr[27:4], addr[1:0], memWdata[31:8], memWMask[3:1]};

    // FIFO storage has no reset; flushing is done by the pointers and count
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr_q] <= memWdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + AW'(1);
            if (pop)
                rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
            if (push_req && full)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    // Transmit FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            tx        <= 1'b1;
            txIdleIrq <= 1'b0;
        end else begin
            state_q   <= state_n;
            baud_q    <= baud_n;
            idx_q     <= idx_n;
            data_q    <= data_n;
            tx        <= tx_n;
            txIdleIrq <= empty & (state_q == S_IDLE);
        end
    end

    // Next state; the baud counter restarts at 0 on every state entry
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q + BW'(1);
        idx_n   = idx_q;
        data_n  = data_q;
        pop     = 1'b0;
        bit_end = (baud_q == BAUD_LAST);
        case (state_q)
            S_IDLE: begin
                baud_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    data_n  = mem[rptr_q];
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    idx_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    // Chain straight into the next frame with no idle gap
                    if (!empty) begin
                        pop     = 1'b1;
                        data_n  = mem[rptr_q];
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                baud_n  = '0;
                state_n = S_IDLE;
            end
        endcase

        // tx is registered, so it is derived from the state being entered
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = data_n[idx_n];
`ifdef UART_PARITY_EN
            S_PARITY: tx_n = ^data_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 8;
`ifdef UART_PARITY_EN
    localparam int   NBITS = 11;
    localparam logic PAR   = 1'b1;
`else
    localparam int   NBITS = 10;
    localparam logic PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CLK_DIV;
    localparam logic [31:0] A_DATA = 32'h4000_0000;
    localparam logic [31:0] A_STAT = 32'h4000_0004;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] memWdata;
    logic [3:0]  memWMask;
    logic        isStore;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        txIdleIrq;

    mmio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .BASE_NIB(4'h4)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .memWdata  (memWdata),
        .memWMask  (memWMask),
        .isStore   (isStore),
        .sel       (sel),
        .rdata     (rdata),
        .tx        (tx),
        .txIdleIrq (txIdleIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every accepted byte with its push edge and its pop edge.
    // A frame occupies FRAME cycles from its pop edge; the next pop happens at
    // max(push+1, previous pop + FRAME).
    int          pe_q[$];
    int          pp_q[$];
    logic [7:0]  by_q[$];
    int          rst_edge = 0;
    logic        m_ovf = 1'b0;

    function automatic int occ(input int e);
        int c = 0;
        foreach (pp_q[i]) if (pe_q[i] <= e && pp_q[i] > e) c++;
        return c;
    endfunction

    function automatic int frame_at(input int e);
        foreach (pp_q[i]) if (e >= pp_q[i] && e < pp_q[i] + FRAME) return i;
        return -1;
    endfunction

    function automatic logic tx_m(input int e);
        int i = frame_at(e);
        int k;
        logic [7:0] b;
        if (i < 0) return 1'b1;
        b = by_q[i];
        k = (e - pp_q[i]) / CLK_DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic [31:0] stat_m(input int e);
        int c = occ(e);
        logic [3:0] c4;
        c4 = (c > 15) ? 4'hF : c[3:0];
        return {23'b0, PAR, c4, m_ovf, (c == 0), (c == DEPTH), (frame_at(e) >= 0)};
    endfunction

    function automatic logic irq_m(input int e);
        if (e <= rst_edge) return 1'b0;
        return (occ(e - 1) == 0) && (frame_at(e - 1) < 0);
    endfunction

    // Advance one edge; afterwards the bus idles on a STATUS read
    task automatic tick();
        @(posedge clk);
        #1;
        isStore  = 1'b0;
        addr     = A_STAT;
        memWdata = '0;
        memWMask = '0;
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n = cyc + 1;
        int p;
        addr = a; memWdata = d; memWMask = m; isStore = 1'b1;
        if (a[31:28] == 4'h4) begin
            if (a[3:2] == 2'd0 && m[0]) begin
                if (occ(n - 1) == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    p = n + 1;
                    if (pp_q.size() > 0 && pp_q[$] + FRAME > p) p = pp_q[$] + FRAME;
                    pe_q.push_back(n);
                    pp_q.push_back(p);
                    by_q.push_back(d[7:0]);
                end
            end else if (a[3:2] == 2'd1 && m[0] && d[3]) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    task automatic drive_reset();
        reset = 1'b1;
        rst_edge = cyc + 1;
        pe_q.delete(); pp_q.delete(); by_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_idle = {23'b0, PAR, 8'h04};
        drive_reset(); tick();
        drive_reset(); tick();
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %0b want 1", tx); end
        n_cmp++; if (txIdleIrq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %0b want 0", txIdleIrq); end
        n_cmp++; if (rdata !== exp_idle) begin n_bad++; $display("FAIL reset_status: got %h want %h", rdata, exp_idle); end
        reset = 1'b0;
        tick(); tick();
        n_cmp++; if (txIdleIrq !== 1'b1) begin n_bad++; $display("FAIL reset_irq_after: got %0b want 1", txIdleIrq); end
        n_cmp++; if (sel !== 1'b1) begin n_bad++; $display("FAIL reset_sel: got %0b want 1", sel); end
        n_cmp++; if (rdata !== exp_idle) begin n_bad++; $display("FAIL reset_status_after: got %h want %h", rdata, exp_idle); end
    endtask

    task automatic test_single();
        int busy_cnt = 0;
        drive_store(A_DATA, 32'hFFFF_FFA5, 4'b0001);
        tick();
        for (int i = 0; i < FRAME + 6; i++) begin
            n_cmp++; if (tx !== tx_m(cyc)) begin n_bad++; $display("FAIL single_tx: got %0b want %0b cycle %0d", tx, tx_m(cyc), cyc); end
            n_cmp++; if (rdata !== stat_m(cyc)) begin n_bad++; $display("FAIL single_status: got %h want %h cycle %0d", rdata, stat_m(cyc), cyc); end
            n_cmp++; if (txIdleIrq !== irq_m(cyc)) begin n_bad++; $display("FAIL single_irq: got %0b want %0b cycle %0d", txIdleIrq, irq_m(cyc), cyc); end
            busy_cnt += int'(rdata[0]);
            tick();
        end
        n_cmp++; if (busy_cnt != FRAME) begin n_bad++; $display("FAIL single_frame_len: got %0d want %0d", busy_cnt, FRAME); end
    endtask

    task automatic test_back_to_back();
        int busy_cnt = 0;
        drive_store(A_DATA, 32'h55, 4'b0001); tick();
        drive_store(A_DATA, 32'h0F, 4'b0001); tick();
        for (int i = 0; i < 2 * FRAME + 6; i++) begin
            n_cmp++; if (tx !== tx_m(cyc)) begin n_bad++; $display("FAIL b2b_tx: got %0b want %0b cycle %0d", tx, tx_m(cyc), cyc); end
            n_cmp++; if (rdata !== stat_m(cyc)) begin n_bad++; $display("FAIL b2b_status: got %h want %h cycle %0d", rdata, stat_m(cyc), cyc); end
            busy_cnt += int'(rdata[0]);
            tick();
        end
        n_cmp++; if (busy_cnt != 2 * FRAME) begin n_bad++; $display("FAIL b2b_no_gap: busy cycles %0d want %0d", busy_cnt, 2 * FRAME); end
    endtask

    task automatic test_overflow();
        int p;
        logic [31:0] exp_full = {23'b0, PAR, 8'h8B};
        logic [31:0] exp_clr  = {23'b0, PAR, 8'h83};
        logic [31:0] exp_idle = {23'b0, PAR, 8'h04};
        for (int i = 0; i < 10; i++) begin
            drive_store(A_DATA, (i == 0) ? 32'h0 : 32'($urandom), 4'b0001);
            tick();
            n_cmp++; if (rdata !== stat_m(cyc)) begin n_bad++; $display("FAIL ovf_status_%0d: got %h want %h", i, rdata, stat_m(cyc)); end
        end
        n_cmp++; if (rdata !== exp_full) begin n_bad++; $display("FAIL ovf_full: got %h want %h", rdata, exp_full); end
        drive_store(A_STAT, 32'h8, 4'b0001); tick();
        n_cmp++; if (rdata !== exp_clr) begin n_bad++; $display("FAIL ovf_clear: got %h want %h", rdata, exp_clr); end
        p = pp_q[0];
        while (cyc < p + 16) begin
            n_cmp++; if (tx !== tx_m(cyc)) begin n_bad++; $display("FAIL ovf_tx: got %0b want %0b cycle %0d", tx, tx_m(cyc), cyc); end
            tick();
        end
        // Mid data bit 3 of byte 0x00: the line must be low here
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL midframe_tx_low: got %0b want 0", tx); end
        drive_reset(); tick();
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL midreset_tx: got %0b want 1", tx); end
        n_cmp++; if (rdata !== exp_idle) begin n_bad++; $display("FAIL midreset_status: got %h want %h", rdata, exp_idle); end
        n_cmp++; if (txIdleIrq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq: got %0b want 0", txIdleIrq); end
        reset = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL midreset_residual: got %0b want 1 cycle %0d", tx, cyc); end
        end
        n_cmp++; if (rdata !== exp_idle) begin n_bad++; $display("FAIL midreset_status_after: got %h want %h", rdata, exp_idle); end
    endtask

    task automatic test_unselected();
        logic [31:0] exp_idle = {23'b0, PAR, 8'h04};
        drive_store(32'h8000_0000, 32'h5A, 4'hF);
        #1;
        n_cmp++; if (sel !== 1'b0) begin n_bad++; $display("FAIL unsel_sel: got %0b want 0", sel); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL unsel_rdata: got %h want 0", rdata); end
        tick();
        drive_store(32'h4000_0008, 32'hFF, 4'hF); tick();
        drive_store(32'h4000_000C, 32'hFF, 4'hF); tick();
        drive_store(A_DATA, 32'hFF, 4'b1110); tick();
        addr = 32'h4000_000C; #1;
        n_cmp++; if (sel !== 1'b1) begin n_bad++; $display("FAIL rsv_sel: got %0b want 1", sel); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rsv_rdata: got %h want 0", rdata); end
        addr = A_DATA; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL txdata_read: got %h want 0", rdata); end
        tick();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL unsel_tx: got %0b want 1 cycle %0d", tx, cyc); end
            tick();
        end
        n_cmp++; if (rdata !== exp_idle) begin n_bad++; $display("FAIL unsel_status: got %h want %h", rdata, exp_idle); end
    endtask

    task automatic test_random();
        int guard;
        for (int op = 0; op < 150; op++) begin
            int gap = $urandom_range(0, 12);
            int kind = $urandom_range(0, 9);
            logic [3:0] m = 4'($urandom);
            for (int g = 0; g <= gap; g++) begin
                if (g == gap) begin
                    if (kind <= 5) begin
                        if ($urandom_range(0, 3) != 0) m[0] = 1'b1;
                        drive_store({4'h4, 24'($urandom), 2'b00, 2'($urandom)}, $urandom, m);
                    end else if (kind == 6) begin
                        drive_store(A_STAT, $urandom, m);
                    end else if (kind == 7) begin
                        drive_store({4'h4, 24'($urandom), 1'b1, 3'($urandom)}, $urandom, m);
                    end else if (kind == 8) begin
                        drive_store({4'h8, 28'($urandom)}, $urandom, m);
                    end else begin
                        addr = {4'h4, 24'($urandom), 2'b00, 2'($urandom)};
                        memWdata = $urandom; memWMask = 4'hF;
                    end
                end
                tick();
                n_cmp++; if (tx !== tx_m(cyc)) begin n_bad++; $display("FAIL rand_tx: got %0b want %0b cycle %0d", tx, tx_m(cyc), cyc); end
                n_cmp++; if (rdata !== stat_m(cyc)) begin n_bad++; $display("FAIL rand_status: got %h want %h cycle %0d", rdata, stat_m(cyc), cyc); end
                n_cmp++; if (txIdleIrq !== irq_m(cyc)) begin n_bad++; $display("FAIL rand_irq: got %0b want %0b cycle %0d", txIdleIrq, irq_m(cyc), cyc); end
            end
        end
        guard = 0;
        while ((frame_at(cyc) >= 0 || occ(cyc) != 0) && guard < 12 * FRAME) begin
            tick();
            guard++;
            n_cmp++; if (tx !== tx_m(cyc)) begin n_bad++; $display("FAIL drain_tx: got %0b want %0b cycle %0d", tx, tx_m(cyc), cyc); end
            n_cmp++; if (rdata !== stat_m(cyc)) begin n_bad++; $display("FAIL drain_status: got %h want %h cycle %0d", rdata, stat_m(cyc), cyc); end
        end
        n_cmp++; if (guard >= 12 * FRAME) begin n_bad++; $display("FAIL drain_timeout: cycles %0d limit %0d", guard, 12 * FRAME); end
    endtask

    initial begin
        reset = 1'b1; addr = A_STAT; memWdata = '0; memWMask = '0; isStore = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_unselected();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
